tlb_miss_controller: RTL



---
 rtl/tlb_miss_controller.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/tlb_miss_controller.sv
// Fully-associative TLB with a single-level page-table walker for the tlblookup stage.
// Optional TLB_STATS_EN adds saturating hit/miss counters.
module tlb_miss_controller #(
    parameter int ENTRIES = 4,
    parameter int VPN_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [15:0] vaddr,
    input  logic [15:0] ptbr,
    input  logic        flush,
    input  logic        fault_ack,
    output logic        hit,
    output logic [15:0] paddr,
    output logic        enable_tlblookup,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        page_fault
`ifdef TLB_STATS_EN
    ,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
`endif
);

    localparam int OFF_W = 16 - VPN_W;
    localparam int PTR_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        REFILL,
        FAULT
    } state_t;

    state_t             state_q;
    logic [ENTRIES-1:0] valid_q;
    logic [VPN_W-1:0]   tag_q [ENTRIES];
    logic [VPN_W-1:0]   ppn_q [ENTRIES];
    logic [PTR_W-1:0]   ptr_q;
    logic [VPN_W-1:0]   vpn_q;
    logic [VPN_W-1:0]   fill_ppn_q;
    logic               mem_req_q;
    logic [15:0]        mem_addr_q;
    logic               fault_q;

    logic [VPN_W-1:0]   vpn;
    logic               match;
    logic [VPN_W-1:0]   match_ppn;
    logic               lookup;
    logic               miss;
    logic               unused_rdata;

    assign vpn          = vaddr[15:OFF_W];
    assign unused_rdata = ^mem_rdata[14:VPN_W];

    always_comb begin
        match     = 1'b0;
        match_ppn = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!match && valid_q[i] && tag_q[i] == vpn) begin
                match     = 1'b1;
                match_ppn = ppn_q[i];
            end
        end
    end

    // Reset is folded in so the stage is released while reset is held.
    assign lookup = (state_q == IDLE) && valid_in && !reset;
    assign miss   = lookup && !match;

    assign hit              = lookup && match;
    assign paddr            = hit ? {match_ppn, vaddr[OFF_W-1:0]} : 16'h0000;
    assign enable_tlblookup = (state_q == IDLE) && !miss;
    assign mem_req          = mem_req_q;
    assign mem_addr         = mem_addr_q;
    assign page_fault       = fault_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            ptr_q      <= '0;
            vpn_q      <= '0;
            fill_ppn_q <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 16'h0000;
            fault_q    <= 1'b0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                ppn_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (miss) begin
                        mem_addr_q <= ptbr + 16'(vpn);
                        vpn_q      <= vpn;
                        mem_req_q  <= 1'b1;
                        state_q    <= REQ;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        if (mem_rdata[15]) begin
                            fill_ppn_q <= mem_rdata[VPN_W-1:0];
                            state_q    <= REFILL;
                        end else begin
                            fault_q <= 1'b1;
                            state_q <= FAULT;
                        end
                    end
                end
                REFILL: begin
                    if (!flush) begin
                        valid_q[ptr_q] <= 1'b1;
                        tag_q[ptr_q]   <= vpn_q;
                        ppn_q[ptr_q]   <= fill_ppn_q;
                    end
                    ptr_q   <= ptr_q + PTR_W'(1);
                    state_q <= IDLE;
                end
                FAULT: begin
                    if (fault_ack) begin
                        fault_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            // Flush overrides any refill write made in the same cycle.
            if (flush) begin
                valid_q <= '0;
            end
        end
    end

`ifdef TLB_STATS_EN
    logic [15:0] hit_cnt_q;
    logic [15:0] miss_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_cnt_q  <= 16'h0000;
            miss_cnt_q <= 16'h0000;
        end else begin
            if (hit && hit_cnt_q != 16'hFFFF) begin
                hit_cnt_q <= hit_cnt_q + 16'h0001;
            end
            if (miss && miss_cnt_q != 16'hFFFF) begin
                miss_cnt_q <= miss_cnt_q + 16'h0001;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule
